// File: rtl/alu_pkg.sv
// Shared op-code constants, multiply/divide FSM encoding and op-class helpers
// for the EX-stage ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_ADDU  = 5'd1,
    OP_SUB   = 5'd2,
    OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,
    OP_OR    = 5'd5,
    OP_SLT   = 5'd6,
    OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,
    OP_LUI   = 5'd9,
    OP_EQL   = 5'd10,
    OP_BNE   = 5'd11,
    OP_XOR   = 5'd12,
    OP_NOR   = 5'd13,
    OP_SRA   = 5'd14,
    OP_SLTU  = 5'd15,
    OP_MULT  = 5'd16,
    OP_MULTU = 5'd17,
    OP_DIV   = 5'd18,
    OP_DIVU  = 5'd19,
    OP_MFHI  = 5'd20,
    OP_MFLO  = 5'd21,
    OP_MTHI  = 5'd22,
    OP_MTLO  = 5'd23
  } aluOp_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } mdState_t;

  function automatic logic isMdOp(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Ops that touch HI/LO and therefore must wait for the unit to go idle.
  function automatic logic isHiLoOp(input logic [4:0] op);
    return isMdOp(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
           (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: magnitude shift-add / restoring divide over
// WIDTH cycles, then a sign-fix cycle that commits to the HI/LO registers.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdState_t           state, stateNext;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   accHi, accLo, opB;
  logic               isMul, negLo, negHi, divZero;

  logic               start, isSigned, signA, signB;
  logic [WIDTH-1:0]   magA, magB;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic               divGe;
  logic [2*WIDTH-1:0] product, prodFix;
  logic [WIDTH-1:0]   quotFix, remFix;

  assign start    = op_valid && isMdOp(alu_op) && !flush;
  assign isSigned = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign signA    = isSigned && a[WIDTH-1];
  assign signB    = isSigned && b[WIDTH-1];
  assign magA     = signA ? -a : a;
  assign magB     = signB ? -b : b;

  // accHi doubles as product high half / partial remainder, accLo as multiplier / quotient.
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divGe    = divShift >= {1'b0, opB};
  assign divDiff  = divShift - {1'b0, opB};

  assign product  = {accHi, accLo};
  assign prodFix  = negLo ? -product : product;
  assign quotFix  = divZero ? '1 : (negLo ? -accLo : accLo);
  assign remFix   = negHi ? -accHi : accHi;

  assign busy     = (state != MD_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: if (start) stateNext = MD_RUN;
      MD_RUN: begin
        if (flush)                          stateNext = MD_IDLE;
        else if (count == CW'(WIDTH - 1))   stateNext = MD_FIX;
      end
      MD_FIX:  stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opB     <= '0;
      isMul   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            count   <= '0;
            accHi   <= '0;
            accLo   <= magA;
            opB     <= magB;
            isMul   <= (alu_op == OP_MULT) || (alu_op == OP_MULTU);
            negLo   <= signA ^ signB;
            negHi   <= signA;
            divZero <= (b == '0);
          end else if (op_valid && alu_op == OP_MTHI) begin
            hi <= a;
          end else if (op_valid && alu_op == OP_MTLO) begin
            lo <= a;
          end
        end
        MD_RUN: begin
          if (!flush) begin
            count <= count + CW'(1);
            if (isMul) begin
              accHi <= mulSum[WIDTH:1];
              accLo <= {mulSum[0], accLo[WIDTH-1:1]};
            end else begin
              accHi <= divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], divGe};
            end
          end
        end
        MD_FIX: begin
          if (!flush) begin
            if (isMul) begin
              {hi, lo} <= prodFix;
            end else begin
              hi <= remFix;
              lo <= quotFix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: combinational datapath, zero/overflow flags and the stall
// request for HI/LO-dependent ops while the multiply/divide unit is busy.
module alu_md
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [SHW-1:0]   shAmt;
  logic [WIDTH-1:0] sum, diff;

  assign shAmt = a[SHW-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  md_unit #(.WIDTH(WIDTH)) mdUnit (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (alu_op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU:                  result = sum;
      OP_SUBU, OP_EQL, OP_BNE:  result = diff;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLL:  result = b << shAmt;
      OP_SRL:  result = b >> shAmt;
      OP_SRA:  result = $signed(b) >>> shAmt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_LUI:  result = b;
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  // Branch-not-equal reuses the subtractor, so its "taken" sense is inverted.
  assign zero  = (alu_op == OP_BNE) ? (result != '0) : (result == '0);
  assign stall = op_valid && busy && isHiLoOp(alu_op);

endmodule

// File: tb/tb_alu_md.sv
// Randomised and directed bench for alu_md at WIDTH=32, checked against a
// plain-arithmetic reference model of the ALU and HI/LO registers.
module tb_alu_md;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst, op_valid, flush;
  logic [4:0]   alu_op;
  logic [W-1:0] a, b, result, hi, lo;
  logic         zero, ovf, busy, stall;

  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] hiM = '0;
  logic [W-1:0] loM = '0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .alu_op(alu_op), .a(a), .b(b),
    .flush(flush), .result(result), .zero(zero), .ovf(ovf), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] op,
                               input logic [31:0] x, input logic [31:0] y);
    op_valid = v;
    alu_op   = op;
    a        = x;
    b        = y;
    #1;
  endtask

  // Reference for the combinational ops, from the arithmetic definitions.
  task automatic refComb(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic z, output logic v);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    v  = 1'b0;
    case (op)
      OP_ADD, OP_ADDU: begin
        s = sx + sy;
        r = 32'(s);
        v = (op == OP_ADD) && ((s > MAXS) || (s < MINS));
      end
      OP_SUB, OP_SUBU, OP_EQL, OP_BNE: begin
        s = sx - sy;
        r = 32'(s);
        v = (op == OP_SUB) && ((s > MAXS) || (s < MINS));
      end
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NOR:  r = ~(x | y);
      OP_SLL:  r = 32'(longint'(y) * (longint'(1) << x[4:0]));
      OP_SRL:  r = 32'(longint'(y) / (longint'(1) << x[4:0]));
      OP_SRA:  r = 32'(sy >>> x[4:0]);
      OP_SLT:  r = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: r = (x < y) ? 32'd1 : 32'd0;
      OP_LUI:  r = y;
      OP_MFHI: r = hiM;
      OP_MFLO: r = loM;
      default: r = '0;
    endcase
    z = (op == OP_BNE) ? (r != 0) : (r == 0);
  endtask

  task automatic refMd(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      OP_MULT:  begin p = sx * sy; hiM = p[63:32]; loM = p[31:0]; end
      OP_MULTU: begin pu = {32'd0, x} * {32'd0, y}; hiM = pu[63:32]; loM = pu[31:0]; end
      OP_DIV: begin
        if (y == 0) begin loM = '1; hiM = x; end
        else begin p = sx / sy; loM = p[31:0]; p = sx % sy; hiM = p[31:0]; end
      end
      default: begin
        if (y == 0) begin loM = '1; hiM = x; end
        else begin loM = x / y; hiM = x % y; end
      end
    endcase
  endtask

  task automatic checkComb(input string tag);
    logic [31:0] r;
    logic z, v;
    refComb(alu_op, a, b, r, z, v);
    checkOutput({tag, ".result"}, result, r);
    checkOutput({tag, ".zero"}, 32'(zero), 32'(z));
    checkOutput({tag, ".ovf"}, 32'(ovf), 32'(v));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic runMd(input string tag, input logic [4:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    int n;
    @(negedge clk);
    applyStimulus(1'b1, op, x, y);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    refMd(op, x, y);
    checkOutput({tag, ".busyCycles"}, 32'(n), 32'(W + 1));
    checkOutput({tag, ".hi"}, hi, hiM);
    checkOutput({tag, ".lo"}, lo, loM);
  endtask

  initial begin
    logic [4:0] combOps [18];
    logic [4:0] op;
    int n;
    combOps = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
                OP_LUI, OP_EQL, OP_BNE, OP_XOR, OP_NOR, OP_SRA, OP_SLTU, OP_MFHI, OP_MFLO};

    rst   = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    #10;
    checkOutput("reset.hi", hi, 32'd0);
    checkOutput("reset.lo", lo, 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed combinational cases with hand-derived answers.
    @(negedge clk);
    applyStimulus(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h1);
    checkOutput("add.result", result, 32'h80000000);
    checkOutput("add.ovf", 32'(ovf), 32'd1);
    applyStimulus(1'b1, OP_ADDU, 32'h7FFFFFFF, 32'h1);
    checkOutput("addu.ovf", 32'(ovf), 32'd0);
    applyStimulus(1'b1, OP_SUB, 32'd5, 32'd5);
    checkOutput("sub.zero", 32'(zero), 32'd1);
    applyStimulus(1'b1, OP_BNE, 32'd5, 32'd5);
    checkOutput("bne.zero", 32'(zero), 32'd0);
    applyStimulus(1'b1, OP_SRA, 32'd4, 32'h80000000);
    checkOutput("sra.result", result, 32'hF8000000);
    applyStimulus(1'b1, OP_SLTU, 32'hFFFFFFFF, 32'd1);
    checkOutput("sltu.result", result, 32'd0);
    applyStimulus(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1);
    checkOutput("slt.result", result, 32'd1);

    for (int i = 0; i < 80; i++) begin
      op = (i % 8 == 7) ? 5'(24 + $urandom_range(0, 7)) : combOps[$urandom_range(0, 17)];
      applyStimulus(1'(($urandom_range(0, 1))), op, pick(), pick());
      checkComb($sformatf("comb%0d.op%0d", i, op));
    end

    runMd("mult", OP_MULT, 32'hFFFFFFFD, 32'd5);
    checkOutput("mult.hiConst", hi, 32'hFFFFFFFF);
    checkOutput("mult.loConst", lo, 32'hFFFFFFF1);
    runMd("multu", OP_MULTU, 32'hFFFFFFFD, 32'd5);
    checkOutput("multu.hiConst", hi, 32'd4);
    runMd("div", OP_DIV, 32'hFFFFFFF9, 32'd2);
    checkOutput("div.loConst", lo, 32'hFFFFFFFD);
    checkOutput("div.hiConst", hi, 32'hFFFFFFFF);
    runMd("divu0", OP_DIVU, 32'd9, 32'd0);
    checkOutput("divu0.loConst", lo, 32'hFFFFFFFF);
    runMd("divNeg0", OP_DIV, 32'hFFFFFFF9, 32'd0);
    runMd("divMinNeg1", OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("divMinNeg1.loConst", lo, 32'h80000000);
    for (int i = 0; i < 10; i++) begin
      runMd($sformatf("md%0d", i), 5'(OP_MULT + $urandom_range(0, 3)), pick(), pick());
    end

    // MFLO one cycle behind a MULT waits out the remaining busy cycles.
    @(negedge clk);
    applyStimulus(1'b1, OP_MULT, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    applyStimulus(1'b1, OP_ADD, 32'd3, 32'd4);
    checkOutput("addDuringBusy.stall", 32'(stall), 32'd0);
    checkComb("addDuringBusy");
    @(negedge clk);
    applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    refMd(OP_MULT, 32'h12345678, 32'h9ABCDEF0);
    checkOutput("mflo.stallCycles", 32'(n), 32'd32);
    checkComb("mfloAfter");

    @(negedge clk);
    applyStimulus(1'b1, OP_MTHI, 32'h1234, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, OP_MTLO, 32'h5678, 32'd0);
    hiM = 32'h1234;
    checkOutput("mthi.hi", hi, hiM);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    loM = 32'h5678;
    checkOutput("mtlo.lo", lo, loM);

    // Flush mid-divide: unit idles next edge, HI/LO untouched.
    @(negedge clk);
    applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    repeat (8) @(negedge clk);
    #1;
    checkOutput("flush.busyBefore", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush.busy", 32'(busy), 32'd0);
    checkOutput("flush.hi", hi, hiM);
    checkOutput("flush.lo", lo, loM);

    @(negedge clk);
    flush = 1'b1;
    applyStimulus(1'b1, OP_MULT, 32'd3, 32'd3);
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    checkOutput("flushStart.busy", 32'(busy), 32'd0);

    // Reset mid-divide aborts and clears HI/LO.
    @(negedge clk);
    applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7);
    @(negedge clk);
    applyStimulus(1'b0, OP_ADD, 32'd0, 32'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    hiM = '0;
    loM = '0;
    checkOutput("rstMid.busy", 32'(busy), 32'd0);
    checkOutput("rstMid.hi", hi, hiM);
    checkOutput("rstMid.lo", lo, loM);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised EX-stage ALU for the pipelined MIPS core, generalising the single-cycle ALU. It adds XOR/NOR/SRA/SLTU, a signed-overflow flag and a sequential multiply/divide unit with HI/LO registers. Single-cycle ops produce results combinationally in the same cycle. MULT/MULTU/DIV/DIVU run iteratively; `stall` holds the pipeline while a dependent instruction waits.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; must be a power of two ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `op_valid`  in  1  A valid instruction is present in EX this cycle.
- `alu_op`  in  5  Operation code from `alu_pkg`.
- `a`  in  WIDTH  First operand (rs; shift amount for shifts).
- `b`  in  WIDTH  Second operand (rt / immediate).
- `flush`  in  1  Abort any in-flight multiply/divide.
- `result`  out  WIDTH  Combinational result.
- `zero`  out  1  Asserted when `result` == 0. For OP_BNE the sense is inverted: 1 when `result` != 0.
- `ovf`  out  1  Signed overflow, for ADD/SUB only.
- `busy`  out  1  Multiply/divide unit is not idle.
- `stall`  out  1  Equals `op_valid && busy && alu_op ∈ {MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO}`.
- `hi`, `lo`  out  WIDTH  Architectural HI/LO registers.

## Operation
Combinational ops (no state):
- ADD/ADDU/SUB/SUBU/EQL/BNE: WIDTH-bit modulo arithmetic.
  - `ovf` = operand signs agree (SUB: a and ~b) and the result sign differs.
  - ADD/SUB results are still produced when `ovf`=1; the exception is raised elsewhere.
- AND, OR, XOR, NOR: bitwise on `a` and `b`.
- SLL/SRL/SRA: shift `b` by `a[SHW-1:0]`. SRA replicates `b[WIDTH-1]`.
- SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0.
- LUI: `result` = `b`.
- MFHI / MFLO: `result` = `hi` / `lo`.
- All other codes: `result` = 0.

MTHI / MTLO:
- When `op_valid` and not `busy`, write `a` to `hi` / `lo` at the next edge.

Multiply/divide FSM, states IDLE, RUN, FIX:
- IDLE→RUN when `op_valid`, an MD op and not `flush`.
  - Latch operand magnitudes (signed ops), result-sign bits and op kind.
  - Clear the counter.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. Counter increments 0..WIDTH-1; at WIDTH-1 → FIX.
- FIX→IDLE: apply sign correction, then write `hi`/`lo`.
  - Multiply: {hi,lo} = 2·WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: lo = all ones, hi = a, both for signed and unsigned; no trap.
  - Signed DIV of most-negative by −1: lo = most-negative, hi = 0.
- `flush` in RUN/FIX → IDLE next edge. hi/lo unchanged, no write.
- Ops other than MD and MT* are never blocked by `busy`.

Reset:
- hi = lo = 0, state = IDLE, counter = 0.
- Therefore busy = 0, stall = 0.
- `result`/`zero`/`ovf` follow inputs combinationally.

## Timing
- Combinational ops: zero latency, valid the same cycle as inputs.
- MD op accepted at edge E0. `busy` is 1 from after E0 through edge E0+WIDTH+1. hi/lo take the new value at E0+WIDTH+1, the same edge at which `busy` falls. Total occupancy is WIDTH+1 cycles (33 at WIDTH=32).
- A stalled MF*/MT*/MD op proceeds the first cycle `busy`=0 and sees the updated hi/lo.
- MD start and `flush` in the same cycle: no start.
- `rst` mid-operation: immediate abort, values as in Reset.

## Structure
- `alu_pkg` holds the op-code constants: existing ADD..LUI/EQL/BNE codes unchanged, plus XOR, NOR, SRA, SLTU, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO. It also holds the FSM state encoding.
- Sub-module `md_unit` holds the FSM, counter, iterative datapath and HI/LO registers.
- `alu_md` holds the combinational ALU, the flags and the stall logic.

## Test plan
WIDTH=32 for all scenarios.
- ADD a=7FFFFFFF, b=1 → result=80000000, ovf=1. ADDU with the same operands → ovf=0. SUB a=5, b=5 → zero=1. BNE with the same operands → zero=0.
- SRA b=80000000, a=4 → F8000000. SLTU a=FFFFFFFF, b=1 → 0. SLT with the same operands → 1.
- MULT a=FFFFFFFD (−3), b=5 → busy high 33 cycles; hi=FFFFFFFF, lo=FFFFFFF1. MULTU with the same operands → hi=4, lo=FFFFFFF1.
- DIV a=FFFFFFF9 (−7), b=2 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=9, b=0 → lo=FFFFFFFF, hi=9.
- MFLO issued 1 cycle after a MULT → stall=1 for 32 cycles, then result = the new lo. ADD issued during busy → stall=0.
- MTHI 1234 → hi=1234. Start DIV, then assert flush at cycle 10 → busy=0 next cycle, hi=1234 retained. Repeat the DIV with rst at cycle 10 → hi=lo=0.
